// File: rtl/prog_sequencer_pkg.sv
// Shared definitions for prog_sequencer: state encoding, default widths
// and the branch-target LUT contents.
package prog_sequencer_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } seq_state_e;

  localparam int DEF_PC_W  = 10;
  localparam int DEF_IDX_W = 4;

  localparam logic [15:0] LUT_T0 = 16'h0100;
  localparam logic [15:0] LUT_T1 = 16'h0200;
  localparam logic [15:0] LUT_T2 = 16'h0080;
  localparam logic [15:0] LUT_T3 = 16'h0040;
  localparam logic [15:0] LUT_T4 = 16'h03FF;
  localparam logic [15:0] LUT_T5 = 16'h0025;

  // Entries without a programmed target resolve to address 0.
  function automatic logic [15:0] lut_entry(input logic [15:0] idx);
    case (idx)
      16'd0:   return LUT_T0;
      16'd1:   return LUT_T1;
      16'd2:   return LUT_T2;
      16'd3:   return LUT_T3;
      16'd4:   return LUT_T4;
      16'd5:   return LUT_T5;
      default: return 16'h0000;
    endcase
  endfunction

endpackage

// File: rtl/prog_sequencer_jump_lut.sv
// Combinational branch-target lookup: TargetIdx -> PC_W-wide target address.
module jump_lut
  import prog_sequencer_pkg::*;
#(
  parameter int PC_W  = DEF_PC_W,
  parameter int IDX_W = DEF_IDX_W
) (
  input  logic [IDX_W-1:0] i_idx,
  output logic [PC_W-1:0]  o_target
);

  logic [15:0] w_raw;

  // Table lookup, resized to the program-counter width.
  always_comb begin
    w_raw    = lut_entry(16'(i_idx));
    o_target = PC_W'(w_raw);
  end

endmodule

// File: rtl/prog_sequencer.sv
// Program-flow sequencer: PC register, IDLE/RUN/DONE handshake, next-PC select.
// Optional executed-cycle counter on CycleCnt when SEQ_CYCLE_COUNT_EN is defined.
module prog_sequencer
  import prog_sequencer_pkg::*;
#(
  parameter int PC_W  = DEF_PC_W,
  parameter int IDX_W = DEF_IDX_W
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             Start,
  input  logic [PC_W-1:0]  StartAddr,
  input  logic             Jump,
  input  logic             BranchEn,
  input  logic             Zero,
  input  logic             Halt,
  input  logic             Stall,
  input  logic [IDX_W-1:0] TargetIdx,
  output logic [PC_W-1:0]  ProgCtr,
  output logic             Running,
  output logic             Ack
`ifdef SEQ_CYCLE_COUNT_EN
  ,
  output logic [15:0]      CycleCnt
`endif
);

  seq_state_e      r_state;
  seq_state_e      w_state_nxt;
  logic [PC_W-1:0] r_pc;
  logic [PC_W-1:0] w_pc_nxt;
  logic [PC_W-1:0] w_target;
  logic            w_start_acc;
  logic            w_taken;
  logic            r_running;
  logic            r_ack;

  jump_lut #(
    .PC_W  (PC_W),
    .IDX_W (IDX_W)
  ) u_jump_lut (
    .i_idx    (TargetIdx),
    .o_target (w_target)
  );

  // State, PC and status registers; status is derived from the next state.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      r_state   <= ST_IDLE;
      r_pc      <= '0;
      r_running <= 1'b0;
      r_ack     <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_pc      <= w_pc_nxt;
      r_running <= (w_state_nxt == ST_RUN);
      r_ack     <= (w_state_nxt == ST_DONE);
    end
  end

  // Next-state and next-PC selection; Stall outranks Halt, Halt outranks a transfer.
  always_comb begin
    w_state_nxt = r_state;
    w_pc_nxt    = r_pc;
    w_start_acc = 1'b0;
    w_taken     = Jump | (BranchEn & Zero);
    case (r_state)
      ST_IDLE, ST_DONE: begin
        if (Start) begin
          w_state_nxt = ST_RUN;
          w_pc_nxt    = StartAddr;
          w_start_acc = 1'b1;
        end else begin
          w_pc_nxt    = r_pc;
        end
      end
      ST_RUN: begin
        if (Stall) begin
          w_pc_nxt    = r_pc;
        end else if (Halt) begin
          w_state_nxt = ST_DONE;
        end else if (w_taken) begin
          w_pc_nxt    = w_target;
        end else begin
          w_pc_nxt    = r_pc + PC_W'(1);
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
        w_pc_nxt    = '0;
      end
    endcase
  end

  assign ProgCtr = r_pc;
  assign Running = r_running;
  assign Ack     = r_ack;

`ifdef SEQ_CYCLE_COUNT_EN
  logic [15:0] r_cycle_cnt;

  // Counts every RUN cycle including stalls and the halt cycle; saturates.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      r_cycle_cnt <= 16'h0000;
    end else if (w_start_acc) begin
      r_cycle_cnt <= 16'h0000;
    end else if ((r_state == ST_RUN) && (r_cycle_cnt != 16'hFFFF)) begin
      r_cycle_cnt <= r_cycle_cnt + 16'h0001;
    end else begin
      r_cycle_cnt <= r_cycle_cnt;
    end
  end

  assign CycleCnt = r_cycle_cnt;
`endif

endmodule

// File: tb/tb_prog_sequencer.sv
// Self-checking bench for prog_sequencer: a directed vector table plus
// hand-written multi-cycle sequences (cycle counter when SEQ_CYCLE_COUNT_EN).
module tb_prog_sequencer;

  logic       Clk = 1'b0;
  logic       Reset, Start, Jump, BranchEn, Zero, Halt, Stall;
  logic [9:0] StartAddr;
  logic [3:0] TargetIdx;
  logic [9:0] ProgCtr;
  logic       Running, Ack;
`ifdef SEQ_CYCLE_COUNT_EN
  logic [15:0] CycleCnt;
`endif

  int checks   = 0;
  int failures = 0;

  prog_sequencer dut (
    .Clk       (Clk),
    .Reset     (Reset),
    .Start     (Start),
    .StartAddr (StartAddr),
    .Jump      (Jump),
    .BranchEn  (BranchEn),
    .Zero      (Zero),
    .Halt      (Halt),
    .Stall     (Stall),
    .TargetIdx (TargetIdx),
    .ProgCtr   (ProgCtr),
    .Running   (Running),
    .Ack       (Ack)
`ifdef SEQ_CYCLE_COUNT_EN
    ,
    .CycleCnt  (CycleCnt)
`endif
  );

  always #5 Clk = ~Clk;

  typedef struct {
    logic       rst;
    logic       st;
    logic [9:0] addr;
    logic       j;
    logic       b;
    logic       z;
    logic       h;
    logic       s;
    logic [3:0] idx;
    logic [9:0] epc;
    logic       erun;
    logic       eack;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(input logic rst, input logic st, input logic [9:0] addr,
                              input logic j, input logic b, input logic z, input logic h,
                              input logic s, input logic [3:0] idx, input logic [9:0] epc,
                              input logic erun, input logic eack);
    vec_t v;
    v.rst = rst; v.st = st; v.addr = addr; v.j = j; v.b = b; v.z = z;
    v.h = h; v.s = s; v.idx = idx; v.epc = epc; v.erun = erun; v.eack = eack;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic rst, input logic st, input logic [9:0] addr,
                       input logic j, input logic b, input logic z, input logic h,
                       input logic s, input logic [3:0] idx);
    Reset = rst; Start = st; StartAddr = addr; Jump = j; BranchEn = b;
    Zero = z; Halt = h; Stall = s; TargetIdx = idx;
  endtask

  task automatic step();
    @(posedge Clk);
    #1;
  endtask

  initial begin
    //                rst st  addr    j     b     z     h     s     idx    pc     run   ack
    vecs.push_back(mk(1'b1, 1'b1, 10'h010, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0, 10'h000, 1'b0, 1'b0));
    vecs.push_back(mk(1'b1, 1'b1, 10'h010, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0, 10'h000, 1'b0, 1'b0));
    vecs.push_back(mk(1'b0, 1'b1, 10'h010, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0, 10'h010, 1'b1, 1'b0));
    vecs.push_back(mk(1'b0, 1'b1, 10'h3FE, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0, 10'h011, 1'b1, 1'b0));
    vecs.push_back(mk(1'b0, 1'b0, 10'h000, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 4'd3, 10'h012, 1'b1, 1'b0));
    vecs.push_back(mk(1'b0, 1'b0, 10'h000, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 4'd3, 10'h040, 1'b1, 1'b0));
    vecs.push_back(mk(1'b0, 1'b0, 10'h000, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 4'd2, 10'h080, 1'b1, 1'b0));
    vecs.push_back(mk(1'b0, 1'b0, 10'h000, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 4'd1, 10'h200, 1'b1, 1'b0));
    vecs.push_back(mk(1'b0, 1'b0, 10'h000, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 4'd0, 10'h200, 1'b1, 1'b0));
    vecs.push_back(mk(1'b0, 1'b0, 10'h000, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 4'd0, 10'h200, 1'b1, 1'b0));
    vecs.push_back(mk(1'b0, 1'b0, 10'h000, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 4'd0, 10'h200, 1'b0, 1'b1));
    vecs.push_back(mk(1'b0, 1'b0, 10'h000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0, 10'h200, 1'b0, 1'b1));
    vecs.push_back(mk(1'b0, 1'b0, 10'h000, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 4'd2, 10'h200, 1'b0, 1'b1));
    vecs.push_back(mk(1'b0, 1'b1, 10'h3FE, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0, 10'h3FE, 1'b1, 1'b0));
    vecs.push_back(mk(1'b0, 1'b0, 10'h000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0, 10'h3FF, 1'b1, 1'b0));
    vecs.push_back(mk(1'b0, 1'b0, 10'h000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0, 10'h000, 1'b1, 1'b0));
    vecs.push_back(mk(1'b0, 1'b0, 10'h000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0, 10'h001, 1'b1, 1'b0));
    vecs.push_back(mk(1'b0, 1'b0, 10'h000, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 4'd5, 10'h025, 1'b1, 1'b0));
    vecs.push_back(mk(1'b1, 1'b0, 10'h000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0, 10'h000, 1'b0, 1'b0));
    vecs.push_back(mk(1'b0, 1'b0, 10'h000, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 4'd2, 10'h000, 1'b0, 1'b0));
    vecs.push_back(mk(1'b0, 1'b1, 10'h020, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0, 10'h020, 1'b1, 1'b0));
    vecs.push_back(mk(1'b0, 1'b0, 10'h000, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 4'd0, 10'h020, 1'b0, 1'b1));
    vecs.push_back(mk(1'b0, 1'b1, 10'h010, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0, 10'h010, 1'b1, 1'b0));
    vecs.push_back(mk(1'b0, 1'b0, 10'h000, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 4'd9, 10'h000, 1'b1, 1'b0));
    vecs.push_back(mk(1'b0, 1'b0, 10'h000, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 4'd9, 10'h001, 1'b1, 1'b0));
    vecs.push_back(mk(1'b0, 1'b0, 10'h000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 4'd0, 10'h001, 1'b1, 1'b0));
    vecs.push_back(mk(1'b0, 1'b0, 10'h000, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 4'd0, 10'h001, 1'b0, 1'b1));
    vecs.push_back(mk(1'b1, 1'b0, 10'h000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0, 10'h000, 1'b0, 1'b0));

    drive(1'b1, 1'b0, 10'h000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0);
    #2;
    foreach (vecs[i]) begin
      drive(vecs[i].rst, vecs[i].st, vecs[i].addr, vecs[i].j, vecs[i].b,
            vecs[i].z, vecs[i].h, vecs[i].s, vecs[i].idx);
      step();
      chk($sformatf("vec%0d_pc", i), 32'(ProgCtr), 32'(vecs[i].epc));
      chk($sformatf("vec%0d_running", i), 32'(Running), 32'(vecs[i].erun));
      chk($sformatf("vec%0d_ack", i), 32'(Ack), 32'(vecs[i].eack));
    end

    // Long stall with every transfer flag high: PC and RUN must hold.
    drive(1'b0, 1'b1, 10'h155, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0);
    step();
    drive(1'b0, 1'b0, 10'h000, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 4'd4);
    for (int k = 0; k < 8; k++) begin
      step();
      chk("stall_hold_pc", 32'(ProgCtr), 32'h155);
      chk("stall_hold_run", 32'(Running), 32'h1);
    end
    // Stall released with Jump only: LUT[4] = 0x3FF, then increments wrap.
    drive(1'b0, 1'b0, 10'h000, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 4'd4);
    step();
    chk("stall_release_jump", 32'(ProgCtr), 32'h3FF);
    drive(1'b0, 1'b0, 10'h000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0);
    for (int k = 0; k < 6; k++) begin
      step();
      chk("straight_run", 32'(ProgCtr), 32'(k));
    end

`ifdef SEQ_CYCLE_COUNT_EN
    drive(1'b1, 1'b0, 10'h000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0);
    step();
    chk("cnt_reset", 32'(CycleCnt), 32'h0);
    drive(1'b0, 1'b1, 10'h100, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0);
    step();
    chk("cnt_start", 32'(CycleCnt), 32'h0);
    drive(1'b0, 1'b0, 10'h000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0);
    step();
    Stall = 1'b1;
    step();
    Stall = 1'b0;
    step();
    step();
    Halt = 1'b1;
    step();
    Halt = 1'b0;
    chk("cnt_after_halt", 32'(CycleCnt), 32'h5);
    chk("cnt_halt_ack", 32'(Ack), 32'h1);
    step();
    step();
    chk("cnt_held_done", 32'(CycleCnt), 32'h5);
    Start = 1'b1;
    step();
    Start = 1'b0;
    chk("cnt_cleared_restart", 32'(CycleCnt), 32'h0);
    step();
    chk("cnt_first_run", 32'(CycleCnt), 32'h1);
    for (int k = 0; k < 65540; k++) step();
    chk("cnt_saturate", 32'(CycleCnt), 32'hFFFF);
    step();
    chk("cnt_saturate_hold", 32'(CycleCnt), 32'hFFFF);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/prog_sequencer.md
# prog_sequencer

Program-flow sequencer for the single-cycle core: owns the program counter register and the start/halt handshake with the testbench/host. Consumes the instruction decoder's Jump/BranchEn/Halt flags and the ALU Zero flag each cycle, and selects the next PC: increment, LUT branch target, or hold. Sits between the control decoder and the instruction ROM address port.

## Interface
Parameters:
- PC_W, 10, program counter width (ROM depth 2^PC_W)
- IDX_W, 4, branch-target LUT index width (2^IDX_W entries)

Ports:
- Clk  in  1  clock; all state updates on rising edge
- Reset  in  1  synchronous, active-high reset
- Start  in  1  request to begin execution; level-sampled in IDLE and DONE
- StartAddr  in  PC_W  entry address loaded when Start is accepted
- Jump  in  1  unconditional transfer, from decoder
- BranchEn  in  1  conditional transfer, taken when Zero=1
- Zero  in  1  ALU zero flag for the current instruction
- Halt  in  1  current instruction is the halt opcode
- Stall  in  1  hold PC this cycle (multi-cycle data-memory op)
- TargetIdx  in  IDX_W  LUT index field from the current instruction
- ProgCtr  out  PC_W  registered address to instruction ROM
- Running  out  1  high while in RUN
- Ack  out  1  program finished; held until next Start accepted
- CycleCnt  out  16  executed-cycle count (only with SEQ_CYCLE_COUNT_EN)

## Operation
- States: IDLE, RUN, DONE.
- Reset: state=IDLE, ProgCtr=0, Running=0, Ack=0, CycleCnt=0. Reset overrides all inputs, including mid-RUN.
- IDLE: Start=1 -> ProgCtr<=StartAddr, state<=RUN. Other inputs ignored.
- RUN, priority high to low:
  - Stall=1: ProgCtr holds; Halt/Jump/BranchEn ignored this cycle.
  - Halt=1: state<=DONE, ProgCtr holds (points at halt instruction).
  - taken = Jump | (BranchEn & Zero): ProgCtr<=LUT[TargetIdx].
  - otherwise ProgCtr<=ProgCtr+1, wrapping modulo 2^PC_W (all-ones -> 0).
- Start while in RUN is ignored.
- DONE: Ack=1, ProgCtr holds. Start=1 -> ProgCtr<=StartAddr, state<=RUN, Ack cleared the same edge.
- BranchEn with Zero=0 is a plain increment. Jump and BranchEn both high: taken regardless of Zero.

## Timing
- ProgCtr, Running, Ack are registered; state changes visible one cycle after the sampling edge.
- Decoder/ALU inputs are combinational from the instruction at current ProgCtr; sampled the same cycle.
- Start accepted at edge N -> Running=1, ProgCtr=StartAddr after N.
- Halt sampled at edge N -> Running=0, Ack=1 after N.
- Next-PC latency: one cycle for every path; no bubbles, no prediction.
- LUT read is combinational; no added latency.

## Configuration
- SEQ_CYCLE_COUNT_EN defined: CycleCnt port present; cleared on Start acceptance, +1 on every RUN cycle (stall cycles included, halt cycle included), saturates at 16'hFFFF, holds in IDLE/DONE.
- Not defined: CycleCnt port and counter absent; all other behaviour identical.

## Structure
- Shared package: state encoding (IDLE/RUN/DONE), default PC_W/IDX_W, branch-target LUT contents as constants.
- One sub-module: jump_lut, combinational, TargetIdx -> PC_W target, contents from package. Unused entries return 0.

## Test plan
- Reset with Start=1 held -> after reset edge ProgCtr=0, Running=0, Ack=0; next edge ProgCtr=StartAddr (e.g. 0x010), Running=1.
- Straight-line run from 0x3FE, no flags -> ProgCtr 0x3FE, 0x3FF, 0x000 (wrap).
- BranchEn=1, TargetIdx=3, Zero=0 then Zero=1 with LUT[3]=0x040 -> first PC+1, then 0x040; Jump=1 with Zero=0 -> target taken.
- Stall=1 for 2 cycles with Halt=1 and Jump=1 -> ProgCtr holds, stays RUN; Stall drops with Halt=1 -> next cycle Ack=1, Running=0, ProgCtr unchanged.
- Reset asserted mid-RUN at PC 0x025 -> next cycle IDLE, ProgCtr=0, Ack=0; DONE then Start=1 -> Ack=0, ProgCtr=StartAddr, Running=1.
- With SEQ_CYCLE_COUNT_EN: 5 RUN cycles incl. halt -> CycleCnt=5, held in DONE, cleared on restart; forced long run saturates at 0xFFFF.
